// File: rtl/mode_select.sv
// rtl/mode_select.sv - front-panel mode selector with debounced next/prev buttons and direct load
// mode_select_btn: per-button synchroniser, debounce level FSM and release pulse.

module mode_select_btn #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rel
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} level_t;

    level_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          s1, s2, db_prev;
    logic          db;

    assign db = (state == PRESSED);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            state   <= RELEASED;
            cnt     <= '0;
            db_prev <= 1'b0;
        end else begin
            s1      <= btn;
            s2      <= s1;
            state   <= state_next;
            cnt     <= cnt_next;
            db_prev <= db;
        end
    end

    // The counter only runs while the synchronised level disagrees with the accepted one.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        if (s2 != db) begin
            if (cnt == CNT_LAST) begin
                state_next = s2 ? PRESSED : RELEASED;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    assign rel = db_prev & ~db;

endmodule

module mode_select #(
    parameter  int NUM_MODES       = 4,
    parameter  int DEBOUNCE_CYCLES = 250000,
    parameter  int RESET_MODE      = 0,
    localparam int MW              = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 btn_next,
    input  logic                 btn_prev,
    input  logic                 sel_valid,
    input  logic [MW-1:0]        sel_mode,
    output logic [MW-1:0]        mode,
    output logic [NUM_MODES-1:0] mode_onehot,
    output logic                 mode_changed,
    output logic                 is_dec
);

    localparam logic [MW-1:0] LAST_MODE  = MW'(NUM_MODES - 1);
    localparam logic [MW-1:0] RST_MODE   = MW'(RESET_MODE);
    localparam logic [MW:0]   MODE_COUNT = (MW + 1)'(NUM_MODES);

    logic          rel_next, rel_prev;
    logic [MW-1:0] mode_next;

    function automatic logic [NUM_MODES-1:0] decode(input logic [MW-1:0] m);
        logic [NUM_MODES-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            oh[i] = (m == MW'(i));
        end
        return oh;
    endfunction

    mode_select_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_next (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_next),
        .rel   (rel_next)
    );

    mode_select_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_prev (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_prev),
        .rel   (rel_prev)
    );

    // Valid direct load wins outright; an out-of-range load falls through to the buttons.
    always_comb begin
        mode_next = mode;
        if (sel_valid && ({1'b0, sel_mode} < MODE_COUNT)) begin
            mode_next = sel_mode;
        end else if (rel_next && rel_prev) begin
            mode_next = mode;
        end else if (rel_next) begin
            mode_next = (mode == LAST_MODE) ? '0 : mode + 1'b1;
        end else if (rel_prev) begin
            mode_next = (mode == '0) ? LAST_MODE : mode - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode         <= RST_MODE;
            mode_onehot  <= decode(RST_MODE);
            is_dec       <= (RST_MODE == '0);
            mode_changed <= 1'b0;
        end else begin
            mode         <= mode_next;
            mode_onehot  <= decode(mode_next);
            is_dec       <= (mode_next == '0);
            mode_changed <= (mode_next != mode);
        end
    end

endmodule
